// File: rtl/input_debounce_sync.sv
// Two-flop synchroniser plus per-bit stability-counter debounce for buttons and switches.
// Buttons additionally get registered press/release pulses and a saturating long-hold flag.
module input_debounce_sync #(
  parameter int N_BTN           = 5,
  parameter int N_SW            = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 100000000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [N_BTN-1:0] i_btn_raw,
  input  logic [N_SW-1:0]  i_sw_raw,
  output logic [N_BTN-1:0] o_btn,
  output logic [N_SW-1:0]  o_sw,
  output logic [N_BTN-1:0] o_btn_press,
  output logic [N_BTN-1:0] o_btn_release,
  output logic [N_BTN-1:0] o_btn_hold
);

  localparam int N_IN   = N_BTN + N_SW;
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

  logic [N_IN-1:0] raw_in;
  logic [N_IN-1:0] sync1_q;
  logic [N_IN-1:0] sync2_q;
  logic [N_IN-1:0] stable_q;
  logic [N_IN-1:0] stable_d;

  assign raw_in = {i_sw_raw, i_btn_raw};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
    end else begin
      sync1_q  <= raw_in;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_db
      logic [DB_W-1:0] cnt_q;
      logic [DB_W-1:0] cnt_d;
      logic            level_d;

      // Any sample matching the accepted level restarts the count.
      always_comb begin
        cnt_d   = '0;
        level_d = stable_q[gi];
        if (sync2_q[gi] != stable_q[gi]) begin
          if (cnt_q == DB_LAST) begin
            level_d = sync2_q[gi];
          end else begin
            cnt_d = cnt_q + DB_W'(1);
          end
        end
      end

      assign stable_d[gi] = level_d;

      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  logic [N_BTN-1:0] btn_q;
  logic [N_BTN-1:0] btn_d;
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] release_q;
  logic [N_BTN-1:0] hold_q;
  logic [N_BTN-1:0] hold_d;

  assign btn_q = stable_q[N_BTN-1:0];
  assign btn_d = stable_d[N_BTN-1:0];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      press_q   <= '0;
      release_q <= '0;
      hold_q    <= '0;
    end else begin
      press_q   <= btn_d & ~btn_q;
      release_q <= ~btn_d & btn_q;
      hold_q    <= hold_d;
    end
  end

  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_hold
      logic [HOLD_W-1:0] hcnt_q;
      logic [HOLD_W-1:0] hcnt_d;

      // Counting starts the cycle after the level rises, so the flag lands HOLD_CYCLES edges later.
      always_comb begin
        hcnt_d = hcnt_q;
        if (!btn_d[gi]) begin
          hcnt_d = '0;
        end else if (btn_q[gi] && (hcnt_q != HOLD_MAX)) begin
          hcnt_d = hcnt_q + HOLD_W'(1);
        end
      end

      assign hold_d[gi] = btn_d[gi] && (hcnt_d == HOLD_MAX);

      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          hcnt_q <= '0;
        end else begin
          hcnt_q <= hcnt_d;
        end
      end
    end
  endgenerate

  assign o_btn         = stable_q[N_BTN-1:0];
  assign o_sw          = stable_q[N_IN-1:N_BTN];
  assign o_btn_press   = press_q;
  assign o_btn_release = release_q;
  assign o_btn_hold    = hold_q;

endmodule

// File: tb/tb_input_debounce_sync.sv
// Bench for input_debounce_sync: directed scenarios plus random bouncing inputs,
// checked every cycle against a sliding-window model of the debounce rules.
module tb_input_debounce_sync;

  localparam int NB   = 5;
  localparam int NS   = 8;
  localparam int NI   = NB + NS;
  localparam int DB   = 8;
  localparam int HOLD = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic [NS-1:0] sw_raw = '0;
  logic [NB-1:0] o_btn, o_press, o_release, o_hold;
  logic [NS-1:0] o_sw;

  input_debounce_sync #(
    .N_BTN(NB), .N_SW(NS), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_btn_raw(btn_raw), .i_sw_raw(sw_raw),
    .o_btn(o_btn), .o_sw(o_sw), .o_btn_press(o_press),
    .o_btn_release(o_release), .o_btn_hold(o_hold)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: raw samples per edge; a level flips once the last DB synchronised
  // samples (raw delayed two edges) all disagree with it.
  logic [NI-1:0] hist[$];
  logic [NI-1:0] m_lvl;
  logic [NB-1:0] m_press, m_rel, m_hold;
  int            rise_t[NB];
  int            t;

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < DB + 2; k++) hist.push_back('0);
    m_lvl = '0; m_press = '0; m_rel = '0; m_hold = '0; t = 0;
    for (int b = 0; b < NB; b++) rise_t[b] = 0;
  endtask

  task automatic model_edge(input logic [NI-1:0] raw);
    logic [NI-1:0] prev;
    logic          all_diff;
    t++;
    hist.push_front(raw);
    void'(hist.pop_back());
    prev = m_lvl;
    for (int b = 0; b < NI; b++) begin
      all_diff = 1'b1;
      for (int j = 2; j < DB + 2; j++) if (hist[j][b] == prev[b]) all_diff = 1'b0;
      if (all_diff) m_lvl[b] = ~prev[b];
    end
    m_press = m_lvl[NB-1:0] & ~prev[NB-1:0];
    m_rel   = ~m_lvl[NB-1:0] & prev[NB-1:0];
    for (int b = 0; b < NB; b++) begin
      if (m_press[b]) rise_t[b] = t;
      m_hold[b] = m_lvl[b] && ((t - rise_t[b]) >= HOLD);
    end
  endtask

  // Starts and ends on a falling edge; one active edge per call.
  task automatic step(input logic [NB-1:0] b, input logic [NS-1:0] s);
    btn_raw = b;
    sw_raw  = s;
    @(posedge clk);
    model_edge({s, b});
    #1;
    check_eq("o_btn", 32'(o_btn), 32'(m_lvl[NB-1:0]));
    check_eq("o_sw", 32'(o_sw), 32'(m_lvl[NI-1:NB]));
    check_eq("o_btn_press", 32'(o_press), 32'(m_press));
    check_eq("o_btn_release", 32'(o_release), 32'(m_rel));
    check_eq("o_btn_hold", 32'(o_hold), 32'(m_hold));
    $display("edge %0d raw_b=%b raw_s=%h btn=%b sw=%h prs=%b rel=%b hold=%b",
             t, b, s, o_btn, o_sw, o_press, o_release, o_hold);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_btn"}, 32'(o_btn), 32'd0);
    check_eq({tag, "_sw"}, 32'(o_sw), 32'd0);
    check_eq({tag, "_press"}, 32'(o_press), 32'd0);
    check_eq({tag, "_release"}, 32'(o_release), 32'd0);
    check_eq({tag, "_hold"}, 32'(o_hold), 32'd0);
  endtask

  task automatic do_reset(input logic [NB-1:0] b, input logic [NS-1:0] s);
    @(negedge clk);
    rst = 1'b1;
    btn_raw = b;
    sw_raw  = s;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_all_zero("reset_state");
  endtask

  initial begin
    int rise, hold_at, fall, t0, cnt_p, cnt_r, cnt_h, flag, rise_b, rise_s;
    logic prev_hold;
    logic [NI-1:0] cur;

    model_reset();

    // Button 0 high from reset release.
    do_reset(5'b00001, 8'h00);
    rise = -1; hold_at = -1; cnt_p = 0;
    for (int k = 0; k < 35; k++) begin
      step(5'b00001, 8'h00);
      if (o_btn[0] && rise < 0) rise = t;
      if (o_hold[0] && hold_at < 0) hold_at = t;
      if (o_press[0]) cnt_p++;
    end
    check_eq("btn0_rise_edge", rise, 10);
    check_eq("btn0_hold_edge", hold_at, 30);
    check_eq("btn0_press_count", cnt_p, 1);

    // Switch 3 bounce: high 5, low 3, high 6, low.
    flag = 0;
    for (int k = 0; k < 30; k++) begin
      step(5'b00001, ((k < 5) || (k >= 8 && k < 14)) ? 8'h08 : 8'h00);
      if (o_sw[3]) flag = 1;
    end
    check_eq("sw3_bounce_rejected", flag, 0);

    // Clean release of button 0.
    fall = -1; t0 = -1; cnt_r = 0;
    for (int k = 0; k < 12; k++) begin
      prev_hold = o_hold[0];
      step(5'b00000, 8'h00);
      if (t0 < 0) t0 = t;
      if (!o_btn[0] && fall < 0) begin
        fall = t;
        check_eq("btn0_hold_clear_same_edge", {30'd0, prev_hold, o_hold[0]}, 32'b10);
      end
      if (o_release[0]) cnt_r++;
    end
    check_eq("btn0_fall_edge", fall - t0 + 1, 10);
    check_eq("btn0_release_count", cnt_r, 1);

    // Button 2 held 15 debounced cycles, below the hold threshold.
    cnt_p = 0; cnt_r = 0; cnt_h = 0;
    for (int k = 0; k < 35; k++) begin
      step((k < 15) ? 5'b00100 : 5'b00000, 8'h00);
      if (o_press[2]) cnt_p++;
      if (o_release[2]) cnt_r++;
      if (o_hold[2]) cnt_h++;
    end
    check_eq("btn2_press_count", cnt_p, 1);
    check_eq("btn2_release_count", cnt_r, 1);
    check_eq("btn2_hold_never", cnt_h, 0);

    // All 13 inputs rise together.
    rise_b = -1; rise_s = -1; cnt_p = 0; t0 = t + 1;
    for (int k = 0; k < 15; k++) begin
      step(5'h1f, 8'hff);
      if (o_btn == 5'h1f && rise_b < 0) rise_b = t;
      if (o_sw == 8'hff && rise_s < 0) rise_s = t;
      if (o_press == 5'h1f) cnt_p++;
    end
    check_eq("all_rise_edge", rise_b - t0 + 1, 10);
    check_eq("all_sw_rise_same_edge", rise_s, rise_b);
    check_eq("all_press_count", cnt_p, 1);
    for (int k = 0; k < 15; k++) step(5'h00, 8'h00);

    // Reset while button 1 holds and button 3 is mid-debounce.
    for (int k = 0; k < 32; k++) step(5'b00010, 8'h00);
    check_eq("btn1_hold_before_reset", 32'(o_hold[1]), 1);
    for (int k = 0; k < 7; k++) step(5'b01010, 8'h00);
    #2 rst = 1'b1;
    #1 check_all_zero("mid_reset");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    rise = -1;
    for (int k = 0; k < 12; k++) begin
      step(5'b01010, 8'h00);
      if (o_btn == 5'b01010 && rise < 0) rise = t;
    end
    check_eq("requalify_edge", rise, 10);

    // Random bouncing inputs.
    cur = '0;
    for (int k = 0; k < 600; k++) begin
      for (int b = 0; b < NI; b++) if ($urandom_range(0, 11) == 0) cur[b] = ~cur[b];
      step(cur[NB-1:0], cur[NI-1:NB]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/input_debounce_sync.md
Name: input_debounce_sync

Overview:
- Front-end conditioning stage for the board's push buttons and DIP switches; sits directly upstream of the status LED controller and other user-input consumers.
- Synchronises each raw asynchronous input into i_clk and debounces it with a per-bit stability counter.
- Provides clean level outputs, plus per-button press, release and long-hold indications.

Parameters:
N_BTN, 5, number of push-button inputs
N_SW, 8, number of DIP-switch inputs
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a change (10 ms @ 100 MHz); must be >= 1
HOLD_CYCLES, 100000000, cycles a debounced button must stay high before o_btn_hold asserts (1 s @ 100 MHz); must be >= 1

Ports:
i_clk  in  1  system clock
i_reset  in  1  reset, asynchronous, active-high
i_btn_raw  in  N_BTN  raw push-button pins, asynchronous
i_sw_raw  in  N_SW  raw DIP-switch pins, asynchronous
o_btn  out  N_BTN  debounced button levels
o_sw  out  N_SW  debounced switch levels
o_btn_press  out  N_BTN  one-cycle pulse on a debounced 0->1 button transition
o_btn_release  out  N_BTN  one-cycle pulse on a debounced 1->0 button transition
o_btn_hold  out  N_BTN  high while a button has been held for at least HOLD_CYCLES

Behaviour:
- Reset: every register, including sync flops, debounce counters, hold counters and all outputs, is cleared to 0 asynchronously on i_reset high.
- Synchronisation:
  - Each raw bit passes through a 2-flop synchroniser (sync1 -> sync2).
  - No logic between the two flops.
- Debounce, per bit, identical for buttons and switches:
  - If sync2 == stable, the counter is cleared.
  - If sync2 != stable and counter < DEBOUNCE_CYCLES-1, the counter increments.
  - If sync2 != stable and counter == DEBOUNCE_CYCLES-1, stable <= sync2 and the counter clears.
  - Any cycle in which sync2 matches stable again restarts the count from 0, so glitches shorter than DEBOUNCE_CYCLES are rejected entirely.
  - Latency: a clean raw change is reflected on o_btn/o_sw exactly DEBOUNCE_CYCLES+2 clock edges after the first edge that samples it.
  - Counter width is clog2(DEBOUNCE_CYCLES+1). The counter never wraps.
- Press/release:
  - Registered outputs.
  - o_btn_press[i] goes high on the same edge o_btn[i] rises and stays high for exactly 1 cycle.
  - o_btn_release[i] behaves the same way on a falling edge of o_btn[i].
  - Press and release for the same bit are never high together.
  - Independent bits may pulse in the same cycle.
- Hold, per button:
  - The hold counter increments each cycle o_btn[i] is 1, saturating at HOLD_CYCLES.
  - o_btn_hold[i] asserts on the edge the counter reaches HOLD_CYCLES, so it rises HOLD_CYCLES edges after o_btn[i] rose.
  - o_btn_hold[i] deasserts, and the counter clears, on the same edge o_btn[i] falls.
  - No repeat pulses.
- Inputs already high at reset release:
  - They are treated as a change from 0.
  - The debounced level rises DEBOUNCE_CYCLES+2 edges after reset deassertion.
  - o_btn_press fires for such buttons. This is required and deterministic.
- Reset mid-operation: all in-flight counts are discarded and outputs drop to 0 immediately. No press or release pulse is generated by reset itself.
- Switch bits have no pulse or hold outputs.

Test Plan:
- DEBOUNCE_CYCLES=8, HOLD_CYCLES=20: hold i_btn_raw[0]=1 from reset release. Required: o_btn[0] rises on edge 10; o_btn_press[0]=1 for that single cycle; o_btn_hold[0] rises on edge 30.
- Bounce rejection: toggle i_sw_raw[3] high for 5 cycles, low 3, high 6, low. Required: o_sw[3] stays 0 throughout and no counter exceeds 7.
- Clean release: after the press above, drop i_btn_raw[0] for 12 cycles. Required: o_btn[0] falls 10 edges after the drop; o_btn_release[0] pulses once; o_btn_hold[0] clears on the same edge.
- Hold-then-release before threshold: press button 2 for 15 debounced cycles (less than HOLD_CYCLES=20). Required: o_btn_hold[2] never asserts; press and release each pulse exactly once.
- Simultaneous events: all 13 raw inputs go high on the same cycle. Required: all of o_btn and o_sw rise on the same edge; o_btn_press=5'b11111 for one cycle.
- Reset mid-count: assert i_reset while a button is 5 cycles into debounce and another is held (o_btn_hold=1). Required: all outputs 0 immediately with no release pulse; after reset release, levels re-qualify after DEBOUNCE_CYCLES+2 edges.
